// File: rtl/rv_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// The HALT_INSTR constant only matters when IF_HALT_ON_ZERO_EN is defined.
package rv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] HALT_INSTR = 32'h00000000;

    typedef enum logic {
        FETCH,
        HALTED
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~32'h00000003;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a synchronous flush.
// The head entry is read straight from storage, so a pushed entry becomes
// visible on head_o the cycle after the push.
module sync_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [63:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  T                       push_data_i,
    input  logic                   pop_i,
    output T                       head_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    // Pops on an empty FIFO and pushes into a full one (without a pop) are ignored.
    assign do_pop  = pop_i & (count_q != '0);
    assign do_push = push_i & ((count_q != (AW+1)'(DEPTH)) | do_pop);

    // Entry storage; no reset needed because the count guards every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: issues sequential word fetches, queues the
// in-order responses tagged with their PC and hands them to decode.
// Redirects flush the queue and discard responses still in flight.
// Optional feature macro: IF_HALT_ON_ZERO_EN (stop fetching on a zero word).
module if_prefetch_queue
    import rv_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        halted
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;
    logic [CW:0]   slots_in_use;
    logic          credit_ok;
    logic          req_accept;
    logic          rsp_keep;
    logic          fifo_push;
    logic          fifo_pop;
    logic [31:0]   redirect_target;

    // Queued entries plus fetches in flight may never exceed the queue size,
    // which is what guarantees a response always finds a free slot.
    assign slots_in_use    = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign credit_ok       = slots_in_use < (CW+1)'(DEPTH);
    assign redirect_target = word_align(redirect_pc);

    assign imem_req_valid = !rst && (state_q == FETCH) && !redirect_valid && credit_ok;
    assign imem_addr      = fetch_pc_q;
    assign req_accept     = imem_req_valid && imem_req_ready;

    assign rsp_keep   = imem_rsp_valid && (drop_cnt_q == '0);
    assign fifo_push  = rsp_keep && !redirect_valid;
    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

    assign instr_valid = !rst && !fifo_empty;
    assign fifo_pop    = instr_valid && instr_ready;
    assign instr       = fifo_head.instr;
    assign instr_pc    = fifo_head.pc;

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

`ifdef IF_HALT_ON_ZERO_EN
    logic halted_q, halted_d;
`endif

    // Next-state logic for PCs, credit/drop counters and the fetch FSM; a redirect overrides everything.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + CW'(req_accept) - CW'(imem_rsp_valid);
        drop_cnt_d    = drop_cnt_q;
`ifdef IF_HALT_ON_ZERO_EN
        halted_d      = halted_q;
`endif

        if (req_accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (imem_rsp_valid && !rsp_keep) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end

        if (rsp_keep) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
        end

`ifdef IF_HALT_ON_ZERO_EN
        if (fifo_push && (imem_rsp_data == HALT_INSTR)) begin
            state_d = HALTED;
        end
        if (fifo_pop && (fifo_head.instr == HALT_INSTR)) begin
            halted_d = 1'b1;
        end
`endif

        // Every fetch still in flight belongs to the abandoned stream, including
        // ones already marked for dropping, so the drop count becomes the whole
        // in-flight count minus the response retiring this cycle.
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            rsp_pc_d   = redirect_target;
            drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
            state_d    = FETCH;
`ifdef IF_HALT_ON_ZERO_EN
            halted_d   = 1'b0;
`endif
        end
    end

    // State registers with synchronous reset; in-flight responses are abandoned on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

`ifdef IF_HALT_ON_ZERO_EN
    // Halt flag rises once the zero word has been consumed by decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halted = !rst && halted_q;
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Testbench for if_prefetch_queue: directed scenarios plus randomized traffic,
// checked every cycle against a request/response queue model of the fetch unit.
module tb_if_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h00000100;
`ifdef IF_HALT_ON_ZERO_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        halted;

    if_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          cyc;
    } memReq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    // Model state: requests the memory still owes, and what decode should see.
    memReq_t     memQ[$];
    entry_t      modelQ[$];
    int          epoch;
    int          cycleNo;
    logic [31:0] expFetchPc;
    bit          fetchHaltExp;
    bit          haltedExp;
    bit          expReq;
    bit          expInstr;

    logic        lastReqValid;
    logic [31:0] lastAddr;
    logic        lastInstrValid;
    logic [31:0] lastInstrPc;
    logic [31:0] lastInstr;
    logic        lastHalted;

    int checks;
    int errors;

    // Instruction memory contents: address 0x10 holds the zero word, all other words are odd.
    function automatic logic [31:0] memData(input logic [31:0] a);
        return (a == 32'h10) ? 32'h0 : (a * 32'd3 + 32'd1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycleNo);
        end
    endtask

    // Compare DUT outputs against the model for the current cycle.
    task automatic checkOutput();
        expReq   = !redirect_valid && !fetchHaltExp && ((modelQ.size() + memQ.size()) < DEPTH);
        expInstr = (modelQ.size() != 0);
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, expReq});
        if (expReq) check("imem_addr", imem_addr, expFetchPc);
        check("instr_valid", {31'b0, instr_valid}, {31'b0, expInstr});
        if (expInstr) begin
            check("instr_pc", instr_pc, modelQ[0].pc);
            check("instr", instr, modelQ[0].data);
        end
        check("halted", {31'b0, halted}, {31'b0, haltedExp});
        lastReqValid   = imem_req_valid;
        lastAddr       = imem_addr;
        lastInstrValid = instr_valid;
        lastInstrPc    = instr_pc;
        lastInstr      = instr;
        lastHalted     = halted;
    endtask

    // Advance the model by one clock edge using this cycle's inputs.
    task automatic updateModel();
        entry_t  e;
        memReq_t r;
        if (expInstr && instr_ready) begin
            e = modelQ.pop_front();
            if (HALT_EN && e.data == 32'h0) haltedExp = 1'b1;
        end
        if (imem_rsp_valid) begin
            r = memQ.pop_front();
            if (!redirect_valid && r.epoch == epoch) begin
                e.pc   = r.addr;
                e.data = memData(r.addr);
                modelQ.push_back(e);
                if (HALT_EN && e.data == 32'h0) fetchHaltExp = 1'b1;
            end
        end
        if (expReq && imem_req_ready) begin
            r.addr  = expFetchPc;
            r.epoch = epoch;
            r.cyc   = cycleNo;
            memQ.push_back(r);
            expFetchPc = expFetchPc + 32'd4;
        end
        if (redirect_valid) begin
            epoch++;
            expFetchPc   = redirect_pc & ~32'h3;
            modelQ.delete();
            fetchHaltExp = 1'b0;
            haltedExp    = 1'b0;
        end
    endtask

    // One clock cycle: drive inputs, check at the falling edge, step the model.
    task automatic applyStimulus(input bit redirV, input logic [31:0] redirPc, input bit reqRdy,
                                 input bit rspEn, input bit instRdy);
        bit rspFire;
        rst            = 1'b0;
        redirect_valid = redirV;
        redirect_pc    = redirPc;
        imem_req_ready = reqRdy;
        instr_ready    = instRdy;
        rspFire        = rspEn && (memQ.size() != 0) && (memQ[0].cyc < cycleNo);
        imem_rsp_valid = rspFire;
        imem_rsp_data  = rspFire ? memData(memQ[0].addr) : $urandom;
        @(negedge clk);
        checkOutput();
        updateModel();
        @(posedge clk);
        #1;
        cycleNo++;
    endtask

    task automatic doReset(input int n);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
            check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
            check("rst_halted", {31'b0, halted}, 32'h0);
            @(posedge clk);
            #1;
            cycleNo++;
        end
        memQ.delete();
        modelQ.delete();
        epoch++;
        expFetchPc   = RESET_PC;
        fetchHaltExp = 1'b0;
        haltedExp    = 1'b0;
    endtask

    // Let outstanding responses return and decode empty the queue.
    task automatic drain();
        int k;
        k = 0;
        while ((memQ.size() != 0 || modelQ.size() != 0) && k < 50) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
            k++;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          accepted;
        int          k;
        int          nAddr;
        int          nPc;
        int          lateAccepts;
        bit          zeroSeen;
        logic [31:0] gotAddr[3];
        logic [31:0] gotPc[3];
        logic [31:0] wrapSeq[3];
        bit          redirV;
        logic [31:0] target;

        checks  = 0;
        errors  = 0;
        epoch   = 0;
        cycleNo = 0;
        doReset(3);

        // Sequential fetch with an always-ready memory and decode.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        check("t1_req0", {31'b0, lastReqValid}, 32'h1);
        check("t1_addr0", lastAddr, 32'h100);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        check("t1_addr1", lastAddr, 32'h104);
        check("t1_not_yet_valid", {31'b0, lastInstrValid}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        check("t1_valid", {31'b0, lastInstrValid}, 32'h1);
        check("t1_pc0", lastInstrPc, 32'h100);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        check("t1_pc1", lastInstrPc, 32'h104);

        // Stalled decode: exactly DEPTH fetches, then one new fetch per pop.
        drain();
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b1, 1'b1);
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
            if (lastReqValid) accepted++;
        end
        check("t2_accepted", accepted, 4);
        check("t2_req_stalled", {31'b0, lastReqValid}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        check("t2_head_pc", lastInstrPc, 32'h300);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        check("t2_refill_req", {31'b0, lastReqValid}, 32'h1);
        check("t2_refill_addr", lastAddr, 32'h310);

        // Redirect with two fetches outstanding; both responses must be dropped.
        drain();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h203, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        check("t3_req", {31'b0, lastReqValid}, 32'h1);
        check("t3_addr", lastAddr, 32'h200);
        k = 0;
        do begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            k++;
        end while (!lastInstrValid && k < 20);
        check("t3_valid", {31'b0, lastInstrValid}, 32'h1);
        check("t3_pc", lastInstrPc, 32'h200);

        // Redirect coinciding with the only outstanding response.
        drain();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h400, 1'b0, 1'b1, 1'b1);
        k = 0;
        do begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            k++;
        end while (!lastInstrValid && k < 20);
        check("t4_valid", {31'b0, lastInstrValid}, 32'h1);
        check("t4_pc", lastInstrPc, 32'h400);

        // Address wrap at the top of the address space.
        drain();
        wrapSeq[0] = 32'hFFFFFFF8;
        wrapSeq[1] = 32'hFFFFFFFC;
        wrapSeq[2] = 32'h00000000;
        for (int i = 0; i < 3; i++) begin
            gotAddr[i] = 32'hDEADBEEF;
            gotPc[i]   = 32'hDEADBEEF;
        end
        nAddr = 0;
        nPc   = 0;
        applyStimulus(1'b1, 32'hFFFFFFF8, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            if (lastReqValid && nAddr < 3) begin
                gotAddr[nAddr] = lastAddr;
                nAddr++;
            end
            if (lastInstrValid && nPc < 3) begin
                gotPc[nPc] = lastInstrPc;
                nPc++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            check("t5_addr", gotAddr[i], wrapSeq[i]);
            check("t5_pc", gotPc[i], wrapSeq[i]);
        end

        // Zero instruction word at 0x10.
        drain();
        applyStimulus(1'b1, 32'h08, 1'b0, 1'b1, 1'b1);
        zeroSeen    = 1'b0;
        lateAccepts = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            if (lastInstrValid && lastInstrPc == 32'h10 && lastInstr == 32'h0) zeroSeen = 1'b1;
            if (lastReqValid && lastAddr > 32'h14) lateAccepts++;
        end
        check("t6_zero_delivered", {31'b0, zeroSeen}, 32'h1);
`ifdef IF_HALT_ON_ZERO_EN
        check("t6_no_fetch_after_halt", lateAccepts, 0);
        check("t6_halted", {31'b0, lastHalted}, 32'h1);
`else
        check("t6_fetch_continues", {31'b0, lateAccepts > 0}, 32'h1);
        check("t6_not_halted", {31'b0, lastHalted}, 32'h0);
`endif
        drain();
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        check("t6_resume_req", {31'b0, lastReqValid}, 32'h1);
        check("t6_resume_addr", lastAddr, 32'h40);

        // Randomized traffic with one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) doReset(2);
            redirV = ($urandom_range(0, 15) == 0);
            target = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 64)) : 32'($urandom);
            applyStimulus(redirV, target, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                          $urandom_range(0, 9) < 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
